// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI serial-NOR flash responder.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;

  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ID,
    ST_STATUS,
    ST_WAIT_END,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer followed by a registered level and rise/fall pulses.
module spi_edge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       sync1;
  logic       sync2;
  logic [1:0] fill;

  // Edges are suppressed until the chain holds real input samples, so a line
  // that is already low when reset drops never looks like a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
      level <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      fill  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge values,
      // which is what makes sync1 -> sync2 -> level a real shift chain.
      sync1 <= din;
      sync2 <= sync1;
      level <= sync2;
      if (fill != 2'd3) fill <= fill + 2'd1;
      rise  <= (fill == 2'd3) &  sync2 & ~level;
      fall  <= (fill == 2'd3) & ~sync2 &  level;
    end
  end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder emulating a minimal serial NOR flash: READ, RDID,
// RDSR, WREN and WRDI, with READ data served from a synchronous byte memory.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [23:0] JEDEC_ID = 24'hEF4017
) (
  input  logic              clk_in_clk,
  input  logic              reset_reset,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              wel,
  output logic [7:0]        last_cmd
);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic ss_rise, ss_fall, ss_level_unused;
  logic mosi, mosi_rise_unused, mosi_fall_unused;

  spi_edge_sync #(.RESET_VAL(1'b0)) u_sclk (
    .clk(clk_in_clk), .rst(reset_reset), .din(spi_sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_edge_sync #(.RESET_VAL(1'b1)) u_ss (
    .clk(clk_in_clk), .rst(reset_reset), .din(spi_ss_n),
    .level(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
  );
  spi_edge_sync #(.RESET_VAL(1'b0)) u_mosi (
    .clk(clk_in_clk), .rst(reset_reset), .din(spi_mosi),
    .level(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t            state, state_d;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [1:0]        byte_idx, byte_idx_d;
  logic [7:0]        shift_in, shift_in_d;
  logic [7:0]        shift_out, shift_out_d;
  logic [23:0]       addr, addr_d;
  logic [7:0]        rdata_q;
  logic              rd_pend;
  logic              miso_d, mem_rd_d, busy_d, wel_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        last_cmd_d;
  logic [7:0]        rx_byte, load_byte, status;
  logic              addr_msb_unused;

  assign addr_msb_unused = addr[23];

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    byte_idx_d  = byte_idx;
    shift_in_d  = shift_in;
    shift_out_d = shift_out;
    addr_d      = addr;
    miso_d      = spi_miso;
    mem_addr_d  = mem_addr;
    mem_rd_d    = 1'b0;
    busy_d      = busy;
    wel_d       = wel;
    last_cmd_d  = last_cmd;
    rx_byte     = {shift_in[6:0], mosi};
    load_byte   = 8'hFF;
    status      = 8'h00;
    status[SR_WEL] = wel;

    if (ss_rise) begin
      if (state == ST_WAIT_END && bit_cnt == 3'd0) wel_d = (last_cmd == OP_WREN);
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b1;
      busy_d    = 1'b0;
    end else if (state == ST_IDLE) begin
      // SCLK edges coincident with the SS_n fall are dropped here.
      if (ss_fall) begin
        state_d    = ST_CMD;
        bit_cnt_d  = 3'd0;
        byte_idx_d = 2'd0;
      end
    end else if (sclk_rise) begin
      bit_cnt_d = bit_cnt + 3'd1;
      case (state)
        ST_CMD: begin
          shift_in_d = rx_byte;
          if (bit_cnt == 3'd7) begin
            last_cmd_d = rx_byte;
            busy_d     = 1'b1;
            case (rx_byte)
              OP_READ:          state_d = ST_ADDR;
              OP_RDID:          state_d = ST_ID;
              OP_RDSR:          state_d = ST_STATUS;
              OP_WREN, OP_WRDI: state_d = ST_WAIT_END;
              default: begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end
            endcase
          end
        end
        ST_ADDR: begin
          addr_d = {addr[22:0], mosi};
          if (bit_cnt == 3'd7) begin
            byte_idx_d = byte_idx + 2'd1;
            if (byte_idx == 2'd2) begin
              state_d    = ST_DATA;
              mem_addr_d = addr_d[ADDR_W-1:0];
              mem_rd_d   = 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (bit_cnt == 3'd7) begin
            mem_addr_d = mem_addr + ADDR_W'(1);
            mem_rd_d   = 1'b1;
          end
        end
        ST_WAIT_END: state_d = ST_IGNORE;
        default: ;
      endcase
    end else if (sclk_fall && (state == ST_DATA || state == ST_ID || state == ST_STATUS)) begin
      if (bit_cnt == 3'd0) begin
        case (state)
          ST_DATA: load_byte = rdata_q;
          ST_ID: begin
            case (byte_idx)
              2'd0:    load_byte = JEDEC_ID[23:16];
              2'd1:    load_byte = JEDEC_ID[15:8];
              2'd2:    load_byte = JEDEC_ID[7:0];
              default: load_byte = 8'h00;
            endcase
            if (byte_idx != 2'd3) byte_idx_d = byte_idx + 2'd1;
          end
          default: load_byte = status;
        endcase
        miso_d      = load_byte[7];
        shift_out_d = {load_byte[6:0], 1'b0};
      end else begin
        miso_d      = shift_out[7];
        shift_out_d = {shift_out[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_in_clk) begin
    if (reset_reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      byte_idx  <= 2'd0;
      shift_in  <= 8'h00;
      shift_out <= 8'h00;
      addr      <= 24'h0;
      rdata_q   <= 8'h00;
      rd_pend   <= 1'b0;
      spi_miso  <= 1'b1;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      busy      <= 1'b0;
      wel       <= 1'b0;
      last_cmd  <= 8'h00;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      byte_idx  <= byte_idx_d;
      shift_in  <= shift_in_d;
      shift_out <= shift_out_d;
      addr      <= addr_d;
      spi_miso  <= miso_d;
      mem_addr  <= mem_addr_d;
      mem_rd    <= mem_rd_d;
      busy      <= busy_d;
      wel       <= wel_d;
      last_cmd  <= last_cmd_d;
      // Memory data arrives one cycle after the strobe; hold it for the next load fall.
      rd_pend   <= mem_rd;
      if (rd_pend) rdata_q <= mem_rdata;
    end
  end

endmodule
